// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - opcodes and FSM state type for the shared ALU controller
package alu_share_pkg;

   localparam logic [2:0] OP_PASSA = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_AND   = 3'b011;
   localparam logic [2:0] OP_OR    = 3'b100;
   localparam logic [2:0] OP_INC   = 3'b101;
   localparam logic [2:0] OP_DEC   = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at a caller-held pointer
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [IDX_W-1:0]   next_ptr
);

   logic found;

   // Candidate order is ptr, ptr+1, ... with wrap; the first valid one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == (int'(ptr) + k) % NUM_REQ)) begin
               found     = 1'b1;
               grant_idx = IDX_W'(j);
               grant[j]  = advance;
            end
         end
      end
      next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - one ALU shared by NUM_REQ requesters, one op in flight
// Optional zero/carry result flags when ALU_SHARE_FLAGS_EN is defined.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [3*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id
`ifdef ALU_SHARE_FLAGS_EN
   ,
   output logic                     rsp_zero,
   output logic                     rsp_carry
`endif
);

   localparam logic [WIDTH:0] ONE = 1;

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        ptr, grant_idx, next_ptr;
   logic [NUM_REQ-1:0]     grant;
   logic                   accept;
   logic [2:0]             sel_op, op_q;
   logic [WIDTH-1:0]       sel_a, sel_b, a_q, b_q;
   logic [ID_W-1:0]        id_q;
   logic [WIDTH:0]         alu_res;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .advance   (state == IDLE),
      .grant     (grant),
      .grant_idx (grant_idx),
      .next_ptr  (next_ptr)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign rsp_valid = (state == RESP);

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (int'(grant_idx) == j) begin
            sel_op = req_op[3*j +: 3];
            sel_a  = req_a[WIDTH*j +: WIDTH];
            sel_b  = req_b[WIDTH*j +: WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are zero-extended so the top bit is carry-out or borrow.
   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_PASSA: alu_res = {1'b0, a_q};
         OP_ADD:   alu_res = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB:   alu_res = {1'b0, a_q} - {1'b0, b_q};
         OP_AND:   alu_res = {1'b0, a_q & b_q};
         OP_OR:    alu_res = {1'b0, a_q | b_q};
         OP_INC:   alu_res = {1'b0, a_q} + ONE;
         OP_DEC:   alu_res = {1'b0, a_q} - ONE;
         OP_PASSB: alu_res = {1'b0, b_q};
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
`ifdef ALU_SHARE_FLAGS_EN
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            ptr  <= next_ptr;
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= grant_idx;
         end
         if (state == EXEC) begin
            rsp_data <= alu_res[WIDTH-1:0];
            rsp_id   <= id_q;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero  <= (alu_res[WIDTH-1:0] == '0);
            rsp_carry <= alu_res[WIDTH];
`endif
         end
      end
   end

`ifndef ALU_SHARE_FLAGS_EN
   logic unused_carry;
   assign unused_carry = alu_res[WIDTH];
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - randomized self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

   localparam int N  = 3;
   localparam int W  = 32;
   localparam int IW = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req_valid = '0;
   logic [N-1:0]       req_ready;
   logic [3*N-1:0]     req_op = '0;
   logic [W*N-1:0]     req_a = '0;
   logic [W*N-1:0]     req_b = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [W-1:0]       rsp_data;
   logic [IW-1:0]      rsp_id;
`ifdef ALU_SHARE_FLAGS_EN
   logic               rsp_zero, rsp_carry;
`endif

   alu_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef ALU_SHARE_FLAGS_EN
      ,
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry)
`endif
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         mptr, lat, exp_id, last_acc;
   bit         busy;
   logic [W-1:0] exp_data;
   bit         exp_carry;
   int         done_ids[$];
   logic [W-1:0] op_tab [8];
   logic [W-1:0] snap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return 1;
         default: return W'($urandom);
      endcase
   endfunction

   function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output bit c);
      longint unsigned la = a;
      longint unsigned lb = b;
      longint unsigned t;
      case (op)
         3'd0:    t = la;
         3'd1:    t = la + lb;
         3'd2:    t = la - lb;
         3'd3:    t = la & lb;
         3'd4:    t = la | lb;
         3'd5:    t = la + 1;
         3'd6:    t = la - 1;
         default: t = lb;
      endcase
      r = W'(t);
      if (op == 3'd1 || op == 3'd5) c = (t >= 64'h1_0000_0000);
      else if (op == 3'd2)          c = (la < lb);
      else if (op == 3'd6)          c = (la == 0);
      else                          c = 1'b0;
   endfunction

   task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]      = v;
      req_op[3*i +: 3]  = op;
      req_a[W*i +: W]   = a;
      req_b[W*i +: W]   = b;
   endtask

   task automatic rnd_req(input int i, input int pct);
      set_req(i, $urandom_range(0, 99) < pct, 3'($urandom), rnd_word(), rnd_word());
   endtask

   // Checks one cycle against the model, then advances to just after the next edge.
   task automatic tick();
      logic [N-1:0] exp_rdy;
      int g;
      #1;
      exp_rdy = '0;
      g = -1;
      if (!busy)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, busy && lat == 0);
      if (busy && lat == 0) begin
         check("rsp_data", rsp_data, exp_data);
         check("rsp_id", rsp_id, exp_id);
`ifdef ALU_SHARE_FLAGS_EN
         check("rsp_zero", rsp_zero, exp_data == 0);
         check("rsp_carry", rsp_carry, exp_carry);
`endif
      end
      last_acc = -1;
      if (g >= 0) begin
         ref_alu(req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W], exp_data, exp_carry);
         exp_id   = g;
         busy     = 1'b1;
         lat      = 1;
         mptr     = (g + 1) % N;
         last_acc = g;
      end else if (busy && lat > 0) begin
         lat--;
      end else if (busy && rsp_ready) begin
         busy = 1'b0;
         done_ids.push_back(exp_id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      busy     = 1'b0;
      lat      = 0;
      mptr     = 0;
      last_acc = -1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_req_ready", req_ready, 0);
`ifdef ALU_SHARE_FLAGS_EN
      check("rst_flags", {rsp_zero, rsp_carry}, 0);
`endif
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic one_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      set_req(0, 1'b1, op, a, b);
      rsp_ready = 1'b1;
      tick();
      req_valid[0] = 1'b0;
      tick();
   endtask

   initial begin
      op_tab = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h00000001,
                 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h00000001};
      do_reset();

      // single request: accepted at N, response visible at N+2
      one_op(3'b001, 32'd5, 32'd7);
      check("single_valid", rsp_valid, 1);
      check("single_data", rsp_data, 32'h0000000C);
      check("single_id", rsp_id, 0);
      tick();
      drain();

      // contention between requesters 0 and 1
      do_reset();
      done_ids.delete();
      rsp_ready = 1'b1;
      rnd_req(0, 100);
      rnd_req(1, 100);
      repeat (13) begin
         tick();
         if (last_acc >= 0) rnd_req(last_acc, 100);
      end
      check("cont_count", done_ids.size() >= 4, 1);
      for (int i = 0; i < 4 && i < done_ids.size(); i++) check("cont_id", done_ids[i], i % 2);
      drain();

      // backpressure in RESP, then reset while stalled
      rsp_ready = 1'b0;
      rnd_req(0, 100);
      rnd_req(1, 100);
      tick();
      if (last_acc >= 0) rnd_req(last_acc, 100);
      tick();
      check("bp_valid", rsp_valid, 1);
      snap = rsp_data;
      repeat (5) begin
         tick();
         check("bp_hold", rsp_data, snap);
         check("bp_no_accept", req_ready, 0);
      end
      do_reset();
      rnd_req(0, 100);
      rnd_req(1, 100);
      rsp_ready = 1'b1;
      #1;
      check("post_rst_grant", req_ready, 3'b001);
      tick();
      drain();

      // every opcode with A=FFFFFFFF, B=1
      for (int op = 0; op < 8; op++) begin
         one_op(3'(op), 32'hFFFFFFFF, 32'h1);
         check("op_tab", rsp_data, op_tab[op]);
`ifdef ALU_SHARE_FLAGS_EN
         if (op == 5) check("inc_flags", {rsp_zero, rsp_carry}, 2'b11);
`endif
         tick();
      end
`ifdef ALU_SHARE_FLAGS_EN
      one_op(3'b010, 32'h0, 32'h1);
      check("sub_flags", {rsp_zero, rsp_carry}, 2'b01);
      tick();
`endif
      drain();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (last_acc >= 0) rnd_req(last_acc, 70);
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rnd_req(i, 100);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
